// File: rtl/mem_wb_ctrl.sv
// MEM-stage request sequencer and MEM/WB register: holds each memory request
// until SRAM_ready, freezes upstream meanwhile, and flags stuck accesses.
module mem_wb_ctrl #(
  parameter int TIMEOUT_CYCLES = 64,
  parameter int DEST_W         = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              exe_valid,
  input  logic              exe_mem_r,
  input  logic              exe_mem_w,
  input  logic              exe_wb_en,
  input  logic [DEST_W-1:0] exe_dest,
  input  logic [31:0]       exe_alu_res,
  input  logic [31:0]       exe_st_val,
  output logic              MEMread,
  output logic              MEMwrite,
  output logic [31:0]       address,
  output logic [31:0]       data,
  input  logic [31:0]       MEM_result,
  input  logic              SRAM_ready,
  output logic              freeze,
  output logic              wb_valid,
  output logic              wb_en,
  output logic              wb_mem_r,
  output logic [DEST_W-1:0] wb_dest,
  output logic [31:0]       wb_alu_res,
  output logic [31:0]       wb_mem_res,
  output logic              mem_timeout
);

  localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [CNT_W-1:0] CNT_LIMIT = CNT_W'(TIMEOUT_CYCLES);

  localparam logic [1:0] S_IDLE   = 2'd0;
  localparam logic [1:0] S_ACCESS = 2'd1;
  localparam logic [1:0] S_ERROR  = 2'd2;

  logic [1:0]        state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              mem_read_q, mem_read_d;
  logic              mem_write_q, mem_write_d;
  logic [31:0]       addr_q, addr_d;
  logic [31:0]       data_q, data_d;
  logic              hold_wb_en_q, hold_wb_en_d;
  logic [DEST_W-1:0] hold_dest_q, hold_dest_d;
  logic              wb_valid_q, wb_valid_d;
  logic              wb_en_q, wb_en_d;
  logic              wb_mem_r_q, wb_mem_r_d;
  logic [DEST_W-1:0] wb_dest_q, wb_dest_d;
  logic [31:0]       wb_alu_res_q, wb_alu_res_d;
  logic [31:0]       wb_mem_res_q, wb_mem_res_d;
  logic              timeout_q, timeout_d;

  assign freeze = (state_q != S_IDLE);

  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    mem_read_d   = mem_read_q;
    mem_write_d  = mem_write_q;
    addr_d       = addr_q;
    data_d       = data_q;
    hold_wb_en_d = hold_wb_en_q;
    hold_dest_d  = hold_dest_q;
    wb_valid_d   = 1'b0;
    wb_en_d      = wb_en_q;
    wb_mem_r_d   = wb_mem_r_q;
    wb_dest_d    = wb_dest_q;
    wb_alu_res_d = wb_alu_res_q;
    wb_mem_res_d = wb_mem_res_q;
    timeout_d    = timeout_q;

    case (state_q)
      S_IDLE: begin
        if (exe_valid) begin
          if (exe_mem_r || exe_mem_w) begin
            // A request flagged as both load and store is served as a load.
            mem_read_d   = exe_mem_r;
            mem_write_d  = exe_mem_w & ~exe_mem_r;
            addr_d       = exe_alu_res;
            data_d       = exe_st_val;
            hold_wb_en_d = exe_wb_en;
            hold_dest_d  = exe_dest;
            cnt_d        = '0;
            state_d      = S_ACCESS;
          end else begin
            wb_valid_d   = 1'b1;
            wb_en_d      = exe_wb_en;
            wb_mem_r_d   = 1'b0;
            wb_dest_d    = exe_dest;
            wb_alu_res_d = exe_alu_res;
          end
        end
      end
      S_ACCESS: begin
        if (SRAM_ready) begin
          wb_valid_d   = 1'b1;
          wb_en_d      = hold_wb_en_q & ~mem_write_q;
          wb_mem_r_d   = mem_read_q;
          wb_dest_d    = hold_dest_q;
          wb_alu_res_d = addr_q;
          if (mem_read_q) wb_mem_res_d = MEM_result;
          mem_read_d   = 1'b0;
          mem_write_d  = 1'b0;
          state_d      = S_IDLE;
        end else if (cnt_q == CNT_LIMIT) begin
          mem_read_d  = 1'b0;
          mem_write_d = 1'b0;
          timeout_d   = 1'b1;
          state_d     = S_ERROR;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      S_ERROR: begin
        timeout_d = 1'b1;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q      <= S_IDLE;
      cnt_q        <= '0;
      mem_read_q   <= 1'b0;
      mem_write_q  <= 1'b0;
      addr_q       <= '0;
      data_q       <= '0;
      hold_wb_en_q <= 1'b0;
      hold_dest_q  <= '0;
      wb_valid_q   <= 1'b0;
      wb_en_q      <= 1'b0;
      wb_mem_r_q   <= 1'b0;
      wb_dest_q    <= '0;
      wb_alu_res_q <= '0;
      wb_mem_res_q <= '0;
      timeout_q    <= 1'b0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      mem_read_q   <= mem_read_d;
      mem_write_q  <= mem_write_d;
      addr_q       <= addr_d;
      data_q       <= data_d;
      hold_wb_en_q <= hold_wb_en_d;
      hold_dest_q  <= hold_dest_d;
      wb_valid_q   <= wb_valid_d;
      wb_en_q      <= wb_en_d;
      wb_mem_r_q   <= wb_mem_r_d;
      wb_dest_q    <= wb_dest_d;
      wb_alu_res_q <= wb_alu_res_d;
      wb_mem_res_q <= wb_mem_res_d;
      timeout_q    <= timeout_d;
    end
  end

  assign MEMread     = mem_read_q;
  assign MEMwrite    = mem_write_q;
  assign address     = addr_q;
  assign data        = data_q;
  assign wb_valid    = wb_valid_q;
  assign wb_en       = wb_en_q;
  assign wb_mem_r    = wb_mem_r_q;
  assign wb_dest     = wb_dest_q;
  assign wb_alu_res  = wb_alu_res_q;
  assign wb_mem_res  = wb_mem_res_q;
  assign mem_timeout = timeout_q;

endmodule
